div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 155 +++++++++++++++
 tb/tb_div_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : 32-bit iterative radix-2 restoring divider (DIV / DIVU).
//                A start is accepted only in IDLE. CALC runs 32 cycles, FIX
//                applies the signs, and DONE pulses done for one cycle.
//                Optional macro DIV_ZERO_FAST_EN: a zero divisor jumps
//                straight from IDLE to DONE.
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        is_signed,
    input  logic        flush,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;   // quotient must be negated in FIX
    logic        neg_rem_q, neg_rem_d;   // remainder takes the dividend's sign
    logic        zero_q, zero_d;         // latched divisor was zero
    logic [31:0] div_q, div_d;           // divisor magnitude
    logic [31:0] rem_q, rem_d;           // partial remainder
    logic [31:0] quo_q, quo_d;           // dividend shifting out / quotient shifting in
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        div_zero_q, div_zero_d;

    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
    assign w_rem_sh = {rem_q, quo_q[31]};
    assign w_diff   = w_rem_sh - {1'b0, div_q};

    // Next-state and datapath; flush overrides everything but reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        zero_d      = zero_q;
        div_d       = div_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_quo_d = is_signed & (opa[31] ^ opb[31]);
                    neg_rem_d = is_signed & opa[31];
                    zero_d    = (opb == 32'd0);
                    div_d     = (is_signed && opb[31]) ? (32'd0 - opb) : opb;
                    quo_d     = (is_signed && opa[31]) ? (32'd0 - opa) : opa;
                    rem_d     = 32'd0;
                    cnt_d     = 6'd0;
                    state_d   = S_CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (opb == 32'd0) begin
                        quotient_d  = 32'hFFFF_FFFF;
                        remainder_d = opa;
                        div_zero_d  = 1'b1;
                        state_d     = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                if (!w_diff[32]) begin
                    rem_d = w_diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = w_rem_sh[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quotient_d  = neg_quo_q ? (32'd0 - quo_q) : quo_q;
                remainder_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
                div_zero_d  = zero_q;
                state_d     = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d     = S_IDLE;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
            div_zero_d  = div_zero_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 6'd0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_q      <= 1'b0;
            div_q       <= 32'd0;
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            zero_q      <= zero_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE) && !flush;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Table-driven self-checking bench for div_unit, plus
//                sequences for flush, reset, start-while-busy and
//                start-in-DONE.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        is_signed;
    logic        flush;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    div_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .is_signed (is_signed),
        .flush     (flush),
        .opa       (opa),
        .opb       (opb),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Launch one operation and follow it to its done pulse.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez,
                         input string name);
        int lat;
        int exp_lat;
        exp_lat = 34;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) exp_lat = 1;
`endif
        @(negedge clk);
        opa = a; opb = b; is_signed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, ".busy_first"}, {31'd0, busy}, {31'd0, exp_lat != 1});
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({name, ".latency"}, lat, exp_lat);
        chk({name, ".quotient"}, quotient, eq);
        chk({name, ".remainder"}, remainder, er);
        chk({name, ".div_zero"}, {31'd0, div_zero}, {31'd0, ez});
        @(negedge clk);
        chk({name, ".done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int k;
        int seen;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
        vecs[2]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0};
        vecs[3]  = '{32'h12345678,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h12345678,   1'b1};
        vecs[4]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[5]  = '{32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2,          1'b0};
        vecs[6]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0};
        vecs[7]  = '{32'hFFFFFFFF,   32'd10,         1'b0, 32'h19999999,   32'd5,          1'b0};
        vecs[8]  = '{32'd7,          32'd100,        1'b0, 32'd0,          32'd7,          1'b0};
        vecs[9]  = '{32'hFFFFFF9C,   32'd7,          1'b0, 32'h24924916,   32'd2,          1'b0};
        vecs[10] = '{32'h80000000,   32'd2,          1'b1, 32'hC0000000,   32'd0,          1'b0};

        resetn = 1'b0; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
        opa = 32'd0; opb = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.quotient", quotient, 32'd0);
        chk("reset.remainder", remainder, 32'd0);
        chk("reset.div_zero", {31'd0, div_zero}, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].z,
                  $sformatf("vec%0d", i));
        end

        // Flush mid-operation: outputs keep the previous result, no done.
        do_op(32'd200, 32'd7, 1'b0, 32'd28, 32'd4, 1'b0, "pre_flush");
        @(negedge clk);
        opa = 32'd50; opb = 32'd5; is_signed = 1'b0; start = 1'b1;
        seen = 0;
        for (k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1;
            if (k == 10) flush = 1'b1;
            if (k == 11) flush = 1'b0;
        end
        chk("flush.busy_at_N11", {31'd0, busy}, 32'd0);
        chk("flush.no_done", seen, 0);
        chk("flush.quotient_kept", quotient, 32'd28);
        chk("flush.remainder_kept", remainder, 32'd4);
        do_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, "after_flush");

        // Reset in the middle of CALC.
        @(negedge clk);
        opa = 32'd999; opb = 32'd3; is_signed = 1'b0; start = 1'b1;
        seen = 0;
        for (k = 1; k <= 21; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1;
            if (k == 20) resetn = 1'b0;
        end
        chk("rst_mid.busy", {31'd0, busy}, 32'd0);
        chk("rst_mid.quotient", quotient, 32'd0);
        chk("rst_mid.remainder", remainder, 32'd0);
        chk("rst_mid.div_zero", {31'd0, div_zero}, 32'd0);
        resetn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("rst_mid.no_done", seen, 0);

        // Start pulsed while busy must not disturb the running divide.
        @(negedge clk);
        opa = 32'd1000; opb = 32'd10; is_signed = 1'b0; start = 1'b1;
        k = 0;
        seen = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            start = (k == 5);
            if (k == 5) begin opa = 32'd9; opb = 32'd3; end
        end
        start = 1'b0;
        chk("busy_start.latency", k, 34);
        chk("busy_start.quotient", quotient, 32'd100);
        chk("busy_start.remainder", remainder, 32'd0);
        // Start in the DONE cycle is ignored.
        opa = 32'd9; opb = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_start.busy", {31'd0, busy}, 32'd0);
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_start.no_done", seen, 0);
        chk("done_start.quotient_kept", quotient, 32'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
